// File: rtl/wallace_mac_acc_if.sv
// Operand/result bundle between an operand source and wallace_mac_acc.
interface wallace_mac_acc_if #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       A;
  logic [3:0]       B;
  logic             clr;
  logic [ACC_W-1:0] acc_out;
  logic             acc_valid;
  logic [CNT_W-1:0] count;
  logic             ovf;

  modport master (
    output in_valid, A, B, clr,
    input  in_ready, acc_out, acc_valid, count, ovf
  );

  modport slave (
    input  in_valid, A, B, clr,
    output in_ready, acc_out, acc_valid, count, ovf
  );
endinterface

// File: rtl/wallace_mac_acc.sv
// Framed multiply-accumulate around a 4x4 Wallace-tree multiplier.
// Define WALLACE_MAC_SAT_EN to saturate the accumulator instead of wrapping.

module wallace (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [7:0] prod
);
  logic [7:0] r0, r1, r2, r3;
  logic [7:0] s1, c1, s2, c2;

  always_comb begin
    r0 = {4'b0, A & {4{B[0]}}};
    r1 = {3'b0, A & {4{B[1]}}, 1'b0};
    r2 = {2'b0, A & {4{B[2]}}, 2'b0};
    r3 = {1'b0, A & {4{B[3]}}, 3'b0};
    // Two 3:2 carry-save layers, then one carry-propagate add; any carry
    // dropped past bit 7 is harmless because the true product is < 256.
    s1 = r0 ^ r1 ^ r2;
    c1 = ((r0 & r1) | (r0 & r2) | (r1 & r2)) << 1;
    s2 = s1 ^ c1 ^ r3;
    c2 = ((s1 & c1) | (s1 & r3) | (c1 & r3)) << 1;
    prod = s2 + c2;
  end
endmodule

module wallace_mac_acc #(
  parameter int ACC_W     = 16,
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 4
) (
  input logic            clk,
  input logic            rst,
  wallace_mac_acc_if.slave bus
);
  localparam int SW = ACC_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DUMP} state_t;

  state_t           state, state_nx;
  logic [3:0]       s1_a, s1_b;
  logic             s1_valid;
  logic [7:0]       prod;
  logic [ACC_W-1:0] acc, acc_nx;
  logic [SW-1:0]    sum;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic             ready, accept, last;

  wallace u_mul (.A(s1_a), .B(s1_b), .prod(prod));

  always_comb begin
    sum = {1'b0, acc} + SW'(prod);
`ifdef WALLACE_MAC_SAT_EN
    acc_nx = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
    acc_nx = sum[ACC_W-1:0];
`endif
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    accept   = 1'b0;
    last     = (cnt == CNT_W'(FRAME_LEN - 1));
    case (state)
      IDLE, RUN: begin
        ready  = 1'b1;
        accept = bus.in_valid && !bus.clr;
        if (accept) state_nx = last ? DRAIN : RUN;
      end
      DRAIN:   state_nx = DUMP;
      DUMP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      acc      <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
    end else if (bus.clr) begin
      state    <= IDLE;
      s1_valid <= 1'b0;
      acc      <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
    end else begin
      state    <= state_nx;
      s1_valid <= accept;
      if (accept) begin
        s1_a <= bus.A;
        s1_b <= bus.B;
        cnt  <= cnt + CNT_W'(1);
      end
      if (state == DUMP) begin
        acc <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end else if (s1_valid) begin
        acc <= acc_nx;
        if (sum[ACC_W]) ovf <= 1'b1;
      end
    end
  end

  always_comb begin
    bus.in_ready  = ready;
    bus.acc_valid = (state == DUMP);
    bus.acc_out   = acc;
    bus.count     = cnt;
    bus.ovf       = ovf;
  end
endmodule
